tag_control: RTL

Tag allocator and tracker between the compute-unit command path and the command buffer/arbiter. Each command is assigned a free 8-bit PSL tag, and its `CommandTagLine` metadata is stored in a tag table. When the PSL response for that tag arrives, the block restores the metadata into a `ResponseBufferLine` and returns the tag to the free pool. It feeds the command arbiter downstream and the response control consumers.

---
 rtl/tag_control.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tag_control.sv
// ---------------------------------------------------------------------------
// tag_control_pkg
//   Shared types for the command-tag path: PSL response codes, the command
//   metadata carried with every tag, and the restored line handed to the
//   response consumers.
// ---------------------------------------------------------------------------
package tag_control_pkg;

    typedef enum logic [7:0] {
        DONE    = 8'h00,
        AERROR  = 8'h01,
        DERROR  = 8'h03,
        NLOCK   = 8'h04,
        NRES    = 8'h05,
        FLUSHED = 8'h06,
        FAULT   = 8'h07,
        FAILED  = 8'h08,
        PAGED   = 8'h0A,
        CONTEXT = 8'h0B
    } psl_response_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [12:0] command;
        logic [63:0] address;
        logic [11:0] size;
        logic [7:0]  cu_id;
    } CommandTagLine;

    typedef struct packed {
        logic          valid;
        CommandTagLine cmd;
        logic [8:0]    response_credits;
        psl_response_t response;
    } ResponseBufferLine;

endpackage

// ---------------------------------------------------------------------------
// tag_control
//   Hands out PSL tags from a circular free pool, remembers the command
//   metadata per tag, and on the matching PSL response restores that metadata
//   into a ResponseBufferLine and returns the tag to the pool.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   cmd_in_valid     command wants a tag
//   cmd_in           command metadata (tag field ignored)
//   cmd_ready        a tag is available and the pool is initialised
//   cmd_out_valid    one-cycle strobe, tagged command on cmd_out
//   cmd_out          cmd_in with the allocated tag
//   rsp_valid        PSL response valid
//   rsp_tag          PSL response tag
//   rsp_code         PSL response code
//   rsp_credits      PSL response credits
//   response_out     restored command + credits + code, valid for one cycle
//   tags_outstanding allocated, unreleased tags
//   init_done        pool filled, normal operation
//   tag_error        sticky: a response arrived for a tag not outstanding
// ---------------------------------------------------------------------------
module tag_control
    import tag_control_pkg::*;
#(
    parameter int TAG_COUNT = 32,
    parameter int TAG_BITS  = $clog2(TAG_COUNT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_in_valid,
    input  CommandTagLine     cmd_in,
    output logic              cmd_ready,
    output logic              cmd_out_valid,
    output CommandTagLine     cmd_out,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_tag,
    input  psl_response_t     rsp_code,
    input  logic [8:0]        rsp_credits,
    output ResponseBufferLine response_out,
    output logic [8:0]        tags_outstanding,
    output logic              init_done,
    output logic              tag_error
);

    localparam int CNT_W = TAG_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(TAG_COUNT - 1);

    typedef enum logic [1:0] {
        TAG_BUFFER_RESET,
        TAG_BUFFER_INIT,
        TAG_BUFFER_POP,
        TAG_BUFFER_READY
    } tag_buffer_state_t;

    tag_buffer_state_t tag_buffer_state;
    tag_buffer_state_t next_state;

    logic [TAG_BITS-1:0] fifo [TAG_COUNT];
    CommandTagLine       tag_table [TAG_COUNT];
    logic [TAG_COUNT-1:0] outstanding;

    logic [TAG_BITS-1:0] head;
    logic [TAG_BITS-1:0] tail;
    logic [CNT_W-1:0]    free_count;

    logic                in_ready;
    logic                in_init;
    logic                clearing;
    logic                alloc;
    logic                rsp_release;
    logic                rsp_in_range;
    logic [TAG_BITS-1:0] alloc_idx;
    logic [TAG_BITS-1:0] rsp_idx;
    CommandTagLine       cmd_tagged;

    // -----------------------------------------------------------------------
    // Allocation / release decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any condition, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        in_ready     = (tag_buffer_state == TAG_BUFFER_READY);
        in_init      = (tag_buffer_state == TAG_BUFFER_INIT);
        clearing     = reset || (tag_buffer_state == TAG_BUFFER_RESET);

        cmd_ready    = in_ready && (free_count != '0);
        alloc        = cmd_in_valid && cmd_ready;
        alloc_idx    = fifo[head];

        cmd_tagged   = cmd_in;
        cmd_tagged.tag = '0;
        cmd_tagged.tag[TAG_BITS-1:0] = alloc_idx;

        // Tags beyond the pool are rejected before the bitmap is consulted;
        // the low bits alone would alias onto a live tag.
        rsp_idx      = rsp_tag[TAG_BITS-1:0];
        rsp_in_range = ({1'b0, rsp_tag} < 9'(TAG_COUNT));
        rsp_release  = rsp_valid && in_ready && rsp_in_range && outstanding[rsp_idx];

        init_done        = in_ready;
        tags_outstanding = in_ready ? (9'(TAG_COUNT) - 9'(free_count)) : '0;
    end

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_buffer_state <= TAG_BUFFER_RESET;
        end else begin
            tag_buffer_state <= next_state;
        end
    end

    always_comb begin
        next_state = TAG_BUFFER_RESET;
        case (tag_buffer_state)
            TAG_BUFFER_RESET: next_state = TAG_BUFFER_INIT;
            // The last init write lands on the same edge as the move to READY.
            TAG_BUFFER_INIT:  next_state = (free_count == LAST_INIT) ? TAG_BUFFER_READY
                                                                      : TAG_BUFFER_INIT;
            TAG_BUFFER_READY: next_state = TAG_BUFFER_READY;
            default:          next_state = TAG_BUFFER_RESET;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pool pointers, free count, outstanding bitmap, error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clearing) begin
            head        <= '0;
            tail        <= '0;
            free_count  <= '0;
            outstanding <= '0;
            tag_error   <= 1'b0;
        end else if (in_init) begin
            // tail doubles as the init write index; it wraps back to 0 on the
            // final write, leaving the pool full with head == tail.
            tail       <= tail + TAG_BITS'(1);
            free_count <= free_count + CNT_W'(1);
            if (rsp_valid) begin
                tag_error <= 1'b1;
            end
        end else begin
            if (alloc) begin
                head                   <= head + TAG_BITS'(1);
                outstanding[alloc_idx] <= 1'b1;
            end
            if (rsp_release) begin
                tail                 <= tail + TAG_BITS'(1);
                outstanding[rsp_idx] <= 1'b0;
            end
            case ({alloc, rsp_release})
                2'b10:   free_count <= free_count - CNT_W'(1);
                2'b01:   free_count <= free_count + CNT_W'(1);
                default: free_count <= free_count;
            endcase
            if (rsp_valid && !rsp_release) begin
                tag_error <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Free-pool FIFO and tag table storage
    // -----------------------------------------------------------------------
    // NOTE: the storage arrays carry no reset; INIT rewrites every pool entry
    // and a table entry is only read after its tag has been allocated.
    always_ff @(posedge clock) begin
        if (in_init) begin
            fifo[tail] <= tail;
        end else if (rsp_release) begin
            fifo[tail] <= rsp_idx;
        end
        if (alloc) begin
            tag_table[alloc_idx] <= cmd_tagged;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clearing) begin
            cmd_out_valid <= 1'b0;
            cmd_out       <= '0;
            response_out  <= '0;
        end else begin
            cmd_out_valid      <= alloc;
            response_out.valid <= rsp_release;
            if (alloc) begin
                cmd_out <= cmd_tagged;
            end
            if (rsp_release) begin
                response_out.cmd              <= tag_table[rsp_idx];
                response_out.response_credits <= rsp_credits;
                response_out.response         <= rsp_code;
            end
        end
    end

endmodule
